freq_error_sampler: RTL and testbench

- Downstream consumer of the digitizer's 8-bit binary frequency word (0..99 Hz, registered, updates one cycle after the PMOD BCD input).
- Decimates `freq` at a fixed sample rate and averages 2^AVG_LOG2 accepted samples.
- Produces signed error (avg − SETPOINT) and change-of-error for the fuzzy controller's fuzzifier, plus a range fault flag.
- Results are delivered over a valid/ready handshake.

---
 rtl/freq_error_sampler.sv | 231 +++++++++++++++++++++++
 tb/tb_freq_error_sampler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_error_sampler.sv
// freq_error_sampler: decimates the digitizer frequency word, averages a window
// of accepted samples and publishes signed error / change-of-error with a range
// fault flag over a valid/ready handshake.
// Optional build macro FREQ_SAMPLE_DEBOUNCE_EN: sample is captured on the tick
// and only accepted if freq is unchanged on the following cycle.
module freq_error_sampler #(
  parameter int unsigned SETPOINT = 50,
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned FREQ_MIN = 46,
  parameter int unsigned FREQ_MAX = 58
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] freq,
  output logic [7:0] err_out,
  output logic [7:0] derr_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       range_fault,
  output logic       sample_reject,
  output logic       overrun
);

  localparam int unsigned CNT_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ACC_W     = 8 + AVG_LOG2;
  localparam int unsigned NCNT_W    = AVG_LOG2 + 1;
  localparam int unsigned N_SAMPLES = 2 ** AVG_LOG2;
  localparam logic [7:0]  FREQ_TOP  = 8'd99;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_CALC    = 2'd1,
    ST_PUBLISH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [NCNT_W-1:0] nacc_q, nacc_d;
  logic [7:0]        avg_q, avg_d;
  logic [7:0]        err_calc_q, err_calc_d;
  logic [7:0]        err_prev_q, err_prev_d;
  logic              first_q, first_d;
  logic [7:0]        err_out_q, err_out_d;
  logic [7:0]        derr_out_q, derr_out_d;
  logic              out_valid_q, out_valid_d;
  logic              range_fault_q, range_fault_d;
  logic              sample_reject_q, sample_reject_d;
  logic              overrun_q, overrun_d;

  logic              tick_c;
  logic              take_c;
  logic              reject_c;
  logic [7:0]        sample_c;
  logic [7:0]        avg_c;
  logic signed [8:0] err9_c;
  logic signed [8:0] derr9_c;
  logic              win_done_c;

  // Saturate a 9-bit signed value into the 8-bit signed range.
  function automatic logic [7:0] sat8(input logic signed [8:0] v);
    if (v > 9'sd127) begin
      return 8'h7F;
    end else if (v < -9'sd128) begin
      return 8'h80;
    end else begin
      return v[7:0];
    end
  endfunction

  // Sample tick divider.
  always_comb begin
    tick_c     = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + CNT_W'(1);
  end

`ifdef FREQ_SAMPLE_DEBOUNCE_EN
  logic [7:0] hold_q, hold_d;
  logic       hold_pend_q, hold_pend_d;

  // Capture on the tick, qualify against the live word one cycle later.
  always_comb begin
    hold_d      = hold_q;
    hold_pend_d = tick_c;
    if (tick_c) begin
      hold_d = freq;
    end
    take_c   = hold_pend_q && (hold_q == freq) && (hold_q <= FREQ_TOP);
    reject_c = hold_pend_q && !((hold_q == freq) && (hold_q <= FREQ_TOP));
    sample_c = hold_q;
  end

  // Debounce holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_pend_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_pend_q <= hold_pend_d;
    end
  end
`else
  // Sample directly on the tick; out-of-range words are discarded.
  always_comb begin
    take_c   = tick_c && (freq <= FREQ_TOP);
    reject_c = tick_c && (freq > FREQ_TOP);
    sample_c = freq;
  end
`endif

  // Window arithmetic shared by the FSM.
  always_comb begin
    avg_c      = 8'(acc_q >> AVG_LOG2);
    err9_c     = $signed({1'b0, avg_c}) - $signed(9'(SETPOINT));
    derr9_c    = $signed({err_calc_q[7], err_calc_q}) - $signed({err_prev_q[7], err_prev_q});
    win_done_c = (nacc_q == NCNT_W'(N_SAMPLES - 1));
  end

  // FSM next state, accumulation and result publication.
  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    nacc_d          = nacc_q;
    avg_d           = avg_q;
    err_calc_d      = err_calc_q;
    err_prev_d      = err_prev_q;
    first_d         = first_q;
    err_out_d       = err_out_q;
    derr_out_d      = derr_out_q;
    range_fault_d   = range_fault_q;
    out_valid_d     = out_valid_q & ~out_ready;
    overrun_d       = 1'b0;
    sample_reject_d = reject_c;

    case (state_q)
      ST_ACCUM: begin
        if (take_c) begin
          acc_d  = acc_q + ACC_W'(sample_c);
          nacc_d = nacc_q + NCNT_W'(1);
          if (win_done_c) begin
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        avg_d      = avg_c;
        err_calc_d = sat8(err9_c);
        // Window restarts empty; a tick landing here seeds the fresh window.
        acc_d      = take_c ? ACC_W'(sample_c) : '0;
        nacc_d     = take_c ? NCNT_W'(1) : '0;
        state_d    = ST_PUBLISH;
      end

      ST_PUBLISH: begin
        state_d = ST_ACCUM;
        if (take_c) begin
          acc_d  = acc_q + ACC_W'(sample_c);
          nacc_d = nacc_q + NCNT_W'(1);
          if (win_done_c) begin
            state_d = ST_CALC;
          end
        end
        err_out_d     = err_calc_q;
        derr_out_d    = first_q ? 8'h00 : sat8(derr9_c);
        range_fault_d = (avg_q < 8'(FREQ_MIN)) || (avg_q > 8'(FREQ_MAX));
        err_prev_d    = err_calc_q;
        first_d       = 1'b0;
        out_valid_d   = 1'b1;
        // Unconsumed result being replaced; a same-cycle consume is not an overrun.
        overrun_d     = out_valid_q & ~out_ready;
      end

      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q      <= '0;
      acc_q           <= '0;
      nacc_q          <= '0;
      avg_q           <= '0;
      err_calc_q      <= '0;
      err_prev_q      <= '0;
      first_q         <= 1'b1;
      err_out_q       <= '0;
      derr_out_q      <= '0;
      out_valid_q     <= 1'b0;
      range_fault_q   <= 1'b0;
      sample_reject_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      tick_cnt_q      <= tick_cnt_d;
      acc_q           <= acc_d;
      nacc_q          <= nacc_d;
      avg_q           <= avg_d;
      err_calc_q      <= err_calc_d;
      err_prev_q      <= err_prev_d;
      first_q         <= first_d;
      err_out_q       <= err_out_d;
      derr_out_q      <= derr_out_d;
      out_valid_q     <= out_valid_d;
      range_fault_q   <= range_fault_d;
      sample_reject_q <= sample_reject_d;
      overrun_q       <= overrun_d;
    end
  end

  assign err_out       = err_out_q;
  assign derr_out      = derr_out_q;
  assign out_valid     = out_valid_q;
  assign range_fault   = range_fault_q;
  assign sample_reject = sample_reject_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_freq_error_sampler.sv
// Directed bench for freq_error_sampler with TICK_DIV=4.
module tb_freq_error_sampler;

  logic       clk;
  logic       rst_n;
  logic [7:0] freq;
  logic [7:0] err_out;
  logic [7:0] derr_out;
  logic       out_valid;
  logic       out_ready;
  logic       range_fault;
  logic       sample_reject;
  logic       overrun;

  int n_cmp;
  int n_err;
  int n_rej;
  int n_ovr;

  logic [7:0] q_err[$];
  logic [7:0] q_derr[$];
  logic       q_rf[$];

  freq_error_sampler #(
    .SETPOINT(50),
    .TICK_DIV(4),
    .AVG_LOG2(2),
    .FREQ_MIN(46),
    .FREQ_MAX(58)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .freq         (freq),
    .err_out      (err_out),
    .derr_out     (derr_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .range_fault  (range_fault),
    .sample_reject(sample_reject),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record each newly published result and count single-cycle pulses.
  initial begin : monitor
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (sample_reject) n_rej++;
      if (overrun) n_ovr++;
      if (out_valid && (!prev_v || overrun)) begin
        q_err.push_back(err_out);
        q_derr.push_back(derr_out);
        q_rf.push_back(range_fault);
      end
      prev_v = out_valid;
    end
  end

  // Reset; release lands on a negedge so the next 4 cycles end in a tick.
  task automatic do_reset(input logic chk_state, input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    if (chk_state) begin
      check({tag, "_rst_err"}, 32'(err_out), 32'h0);
      check({tag, "_rst_derr"}, 32'(derr_out), 32'h0);
      check({tag, "_rst_valid"}, 32'(out_valid), 32'h0);
      check({tag, "_rst_rf"}, 32'(range_fault), 32'h0);
    end
    q_err.delete();
    q_derr.delete();
    q_rf.delete();
    n_rej = 0;
    n_ovr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One tick period with freq held at f; ends on the negedge after the capture.
  task automatic step_tick(input logic [7:0] f);
    freq = f;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic window(input logic [7:0] f);
    repeat (4) step_tick(f);
  endtask

  // Let the last window reach out_valid (2 cycles after its capture edge).
  task automatic drain();
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic expect_result(input string tag, input logic [7:0] e_err,
                               input logic [7:0] e_derr, input logic e_rf);
    check({tag, "_avail"}, 32'(q_err.size() != 0), 32'h1);
    if (q_err.size() != 0) begin
      check({tag, "_err"}, 32'(q_err.pop_front()), 32'(e_err));
      check({tag, "_derr"}, 32'(q_derr.pop_front()), 32'(e_derr));
      check({tag, "_rf"}, 32'(q_rf.pop_front()), 32'(e_rf));
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    n_rej     = 0;
    n_ovr     = 0;
    rst_n     = 1'b0;
    freq      = 8'd50;
    out_ready = 1'b1;

    // 1: reset values, then a nominal window.
    do_reset(1'b1, "t1");
    window(8'd50);
    drain();
    expect_result("t1_res", 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    check("t1_valid_drop", 32'(out_valid), 32'h0);

    // 2: band edges, derr across consecutive windows.
    do_reset(1'b0, "t2");
    window(8'd46);
    window(8'd58);
    drain();
    expect_result("t2_a", 8'hFC, 8'h00, 1'b0);
    expect_result("t2_b", 8'h08, 8'h0C, 1'b0);

    // 3: truncating average, then above and below the band.
    do_reset(1'b0, "t3");
    step_tick(8'd48);
    step_tick(8'd49);
    step_tick(8'd50);
    step_tick(8'd51);
    window(8'd62);
    window(8'd40);
    drain();
    expect_result("t3_a", 8'hFF, 8'h00, 1'b0);
    expect_result("t3_b", 8'h0C, 8'h0D, 1'b1);
    expect_result("t3_c", 8'hF6, 8'hEA, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    check("t3_rf_hold", 32'(range_fault), 32'h1);
    check("t3_valid_clr", 32'(out_valid), 32'h0);

    // 4: invalid words do not advance the window.
    do_reset(1'b0, "t4");
    step_tick(8'd52);
    step_tick(8'h9A);
    step_tick(8'h9A);
    step_tick(8'd52);
    step_tick(8'd52);
    #1;
    check("t4_early", 32'(q_err.size()), 32'h0);
    step_tick(8'd52);
    drain();
    expect_result("t4_res", 8'h02, 8'h00, 1'b0);
    check("t4_rejects", 32'(n_rej), 32'h2);

    // 5: backpressure across two windows overruns once.
    do_reset(1'b0, "t5");
    out_ready = 1'b0;
    window(8'd50);
    window(8'd54);
    drain();
    check("t5_overrun", 32'(n_ovr), 32'h1);
    expect_result("t5_a", 8'h00, 8'h00, 1'b0);
    expect_result("t5_b", 8'h04, 8'h04, 1'b0);
    @(negedge clk);
    #1;
    check("t5_hold_err", 32'(err_out), 32'h04);
    check("t5_hold_valid", 32'(out_valid), 32'h1);
    check("t5_ovr_pulse", 32'(overrun), 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("t5_consumed", 32'(out_valid), 32'h0);
    check("t5_err_kept", 32'(err_out), 32'h04);

    // 6: reset mid-window clears accumulator and restores first-window flag.
    do_reset(1'b0, "t6");
    window(8'd60);
    step_tick(8'd70);
    step_tick(8'd70);
    #1;
    expect_result("t6_pre", 8'h0A, 8'h00, 1'b1);
    do_reset(1'b1, "t6b");
    window(8'd46);
    drain();
    expect_result("t6_post", 8'hFC, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
